// File: rtl/dvp_pattern_source.sv
// dvp_pattern_source: OV5640-style DVP framing with RGB565 test patterns.
// Define DVP_PATTERN_CRC_EN to add a CRC-16/CCITT of each frame's active bytes.
module dvp_pattern_source #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int HTS         = 1896,
  parameter int H_FRONT     = 20,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 10,
  parameter int V_FRONT     = 10,
  parameter int CLK_DIV     = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic [15:0] frames_i,
  input  logic [1:0]  mode_i,
  input  logic [15:0] solid_i,
  output logic        cam_pclk_o,
  output logic        cam_vsync_o,
  output logic        cam_href_o,
  output logic [7:0]  cam_half_pixel_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] crc_o
);

  localparam int PW   = $clog2(CLK_DIV);
  localparam int HW   = $clog2(HTS);
  localparam int HEND = H_FRONT + 2 * H_ACTIVE;

  typedef enum logic [2:0] {
    S_IDLE, S_VS, S_VBP, S_ACT, S_VFP
  } state_t;

  state_t        st, st_n;
  logic [PW-1:0] phase, phase_n;
  logic [HW-1:0] hcnt, hcnt_n, off;
  logic [15:0]   lcnt, lcnt_n, x, pix;
  logic [15:0]   bar_acc, acc8, solid_q;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;
  logic          stop_seen, tick, pre, line_end;
  logic          frame_last, act_byte, done_run;
  logic          vs_entry, idle_entry;

  function automatic logic [15:0] bar_color(input logic [2:0] i);
    logic [15:0] c;
    unique case (i)
      3'd0: c = 16'hFFFF;
      3'd1: c = 16'hFFE0;
      3'd2: c = 16'h07FF;
      3'd3: c = 16'h07E0;
      3'd4: c = 16'hF81F;
      3'd5: c = 16'hF800;
      3'd6: c = 16'h001F;
      3'd7: c = 16'h0000;
    endcase
    return c;
  endfunction

  assign tick       = phase == PW'(CLK_DIV - 1);
  assign pre        = phase == PW'(CLK_DIV - 2);
  assign phase_n    = tick ? '0 : phase + 1'b1;
  assign line_end   = hcnt == HW'(HTS - 1);
  assign frame_last = st == S_VFP && lcnt == 16'(V_FRONT - 1)
                      && line_end;
  assign act_byte   = st == S_ACT && hcnt >= HW'(H_FRONT)
                      && hcnt < HW'(HEND);
  assign off        = hcnt - HW'(H_FRONT);
  assign x          = 16'(off[HW-1:1]);
  assign acc8       = bar_acc + 16'd8;
  assign done_run   = stop_seen || stop_i
                      || (frames_i != '0 && frame_cnt_o == frames_i);
  assign vs_entry   = tick && st_n == S_VS && st != S_VS;
  assign idle_entry = tick && st_n == S_IDLE && st != S_IDLE;

  always_comb begin
    st_n   = st;
    hcnt_n = line_end ? '0 : hcnt + 1'b1;
    lcnt_n = lcnt;
    unique case (st)
      S_IDLE: begin
        hcnt_n = '0;
        lcnt_n = '0;
        if (busy_o) st_n = S_VS;
      end
      S_VS: if (line_end) begin
        lcnt_n = lcnt + 16'd1;
        if (lcnt == 16'(VSYNC_LINES - 1)) begin
          st_n   = S_VBP;
          lcnt_n = '0;
        end
      end
      S_VBP: if (line_end) begin
        lcnt_n = lcnt + 16'd1;
        if (lcnt == 16'(V_BACK - 1)) begin
          st_n   = S_ACT;
          lcnt_n = '0;
        end
      end
      S_ACT: if (line_end) begin
        lcnt_n = lcnt + 16'd1;
        if (lcnt == 16'(V_ACTIVE - 1)) begin
          st_n   = S_VFP;
          lcnt_n = '0;
        end
      end
      S_VFP: if (line_end) begin
        lcnt_n = lcnt + 16'd1;
        if (lcnt == 16'(V_FRONT - 1)) begin
          st_n   = done_run ? S_IDLE : S_VS;
          lcnt_n = '0;
        end
      end
      default: st_n = S_IDLE;
    endcase
  end

  always_comb begin
    pix = 16'h0000;
    unique case (mode_q)
      2'd0:    pix = bar_color(bar_idx);
      2'd1:    pix = x + lcnt;
      2'd2:    pix = (x[5] ^ lcnt[5]) ? 16'hFFFF : 16'h0000;
      default: pix = solid_q;
    endcase
  end

  // Framing decodes straight from period state, which only moves at phase 0.
  assign cam_vsync_o      = st == S_IDLE || st == S_VS || st == S_VFP;
  assign cam_href_o       = act_byte;
  assign cam_half_pixel_o = !act_byte ? 8'h00 :
                            off[0] ? pix[7:0] : pix[15:8];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase        <= '0;
      cam_pclk_o   <= 1'b0;
      st           <= S_IDLE;
      hcnt         <= '0;
      lcnt         <= '0;
      busy_o       <= 1'b0;
      stop_seen    <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      mode_q       <= '0;
      solid_q      <= '0;
      bar_acc      <= '0;
      bar_idx      <= '0;
    end else begin
      phase        <= phase_n;
      cam_pclk_o   <= phase_n >= PW'(CLK_DIV / 2);
      frame_done_o <= pre && frame_last;
      if (st == S_IDLE && !busy_o && start_i) begin
        busy_o      <= 1'b1;
        frame_cnt_o <= '0;
      end
      if (busy_o && stop_i) stop_seen <= 1'b1;
      if (pre && frame_last) frame_cnt_o <= frame_cnt_o + 16'd1;
      if (tick) begin
        st   <= st_n;
        hcnt <= hcnt_n;
        lcnt <= lcnt_n;
        if (!act_byte) begin
          bar_acc <= '0;
          bar_idx <= '0;
        end else if (off[0]) begin
          if (acc8 >= 16'(H_ACTIVE)) begin
            bar_acc <= acc8 - 16'(H_ACTIVE);
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_acc <= acc8;
          end
        end
      end
      if (vs_entry) begin
        mode_q  <= mode_i;
        solid_q <= solid_i;
      end
      if (idle_entry) begin
        busy_o    <= 1'b0;
        stop_seen <= 1'b0;
      end
    end
  end

`ifdef DVP_PATTERN_CRC_EN
  logic [15:0] crc_run;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      crc_run <= 16'hFFFF;
      crc_o   <= '0;
    end else begin
      if (vs_entry) crc_run <= 16'hFFFF;
      else if (tick && act_byte)
        crc_run <= crc_step(crc_run, cam_half_pixel_o);
      if (pre && frame_last) crc_o <= crc_run;
    end
  end
`else
  assign crc_o = '0;
`endif

endmodule

// File: tb/tb_dvp_pattern_source.sv
// tb_dvp_pattern_source: scoreboard bench for dvp_pattern_source.
// Expected bytes come from a per-pixel pattern model queued ahead of the DUT.
module tb_dvp_pattern_source;

  localparam int H_ACTIVE    = 64;
  localparam int V_ACTIVE    = 34;
  localparam int HTS         = 132;
  localparam int H_FRONT     = 2;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int CLK_DIV     = 2;
  localparam int FRAME_CYC   =
    (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * HTS * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic [15:0] frames_i = '0;
  logic [1:0]  mode_i = '0;
  logic [15:0] solid_i = '0;
  logic        cam_pclk_o, cam_vsync_o, cam_href_o;
  logic [7:0]  cam_half_pixel_o;
  logic        busy_o, frame_done_o;
  logic [15:0] frame_cnt_o, crc_o;

  always #5 clk = ~clk;

  dvp_pattern_source #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .HTS(HTS),
    .H_FRONT(H_FRONT), .VSYNC_LINES(VSYNC_LINES),
    .V_BACK(V_BACK), .V_FRONT(V_FRONT), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .stop_i(stop_i), .frames_i(frames_i), .mode_i(mode_i),
    .solid_i(solid_i), .cam_pclk_o(cam_pclk_o),
    .cam_vsync_o(cam_vsync_o), .cam_href_o(cam_href_o),
    .cam_half_pixel_o(cam_half_pixel_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o),
    .crc_o(crc_o)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_done = -1;
  int          done_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] model_crc;
  logic        mon_pclk = 1'b0;
  logic        prev_done = 1'b0;
  logic        low_href = 1'b0;
  logic [7:0]  low_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int mode,
    input logic [15:0] solid, input int x, input int y);
    int b;
    case (mode)
      0: begin
        b = (8 * x) / H_ACTIVE;
        case (b)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      1: return 16'((x + y) % 65536);
      2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
      default: return solid;
    endcase
  endfunction

  function automatic logic [15:0] crc_model(input logic [15:0] c,
                                            input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  task automatic push_frame(input int mode, input logic [15:0] solid);
    logic [15:0] p;
    model_crc = 16'hFFFF;
    for (int y = 0; y < V_ACTIVE; y++)
      for (int x = 0; x < H_ACTIVE; x++) begin
        p = model_pix(mode, solid, x, y);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
        model_crc = crc_model(model_crc, p[15:8]);
        model_crc = crc_model(model_crc, p[7:0]);
      end
  endtask

  initial forever begin
    @(negedge clk);
    if (reset_i) begin
      mon_pclk = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (cam_pclk_o && !mon_pclk) begin
        check("href_stable", {31'd0, cam_href_o}, {31'd0, low_href});
        check("data_stable", {24'd0, cam_half_pixel_o}, {24'd0, low_data});
        if (cam_href_o) begin
          if (exp_q.size() == 0)
            check("extra_byte", {24'd0, cam_half_pixel_o}, 32'hFFFF_FFFF);
          else
            check("pixel_byte", {24'd0, cam_half_pixel_o},
                  {24'd0, exp_q.pop_front()});
        end
      end
      if (!cam_pclk_o) begin
        low_href = cam_href_o;
        low_data = cam_half_pixel_o;
      end
      if (prev_done) begin
        check("done_width", {31'd0, frame_done_o}, 0);
        check("vsync_after_done", {31'd0, cam_vsync_o}, 1);
      end
      if (frame_done_o) begin
        check("vsync_at_done", {31'd0, cam_vsync_o}, 1);
        if (last_done >= 0)
          check("frame_period", cyc - last_done, FRAME_CYC);
        last_done = cyc;
        done_cnt++;
      end
      prev_done = frame_done_o;
      mon_pclk = cam_pclk_o;
    end
  end

  task automatic wait_href();
    int n = 0;
    while (!cam_href_o && n < FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    check("href_seen", {31'd0, cam_href_o}, 1);
  endtask

  task automatic wait_done(input int nframes);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done_o && n < 2 * FRAME_CYC);
    check("done_seen", {31'd0, frame_done_o}, 1);
    check("busy_at_done", {31'd0, busy_o}, 1);
    check("cnt_at_done", {16'd0, frame_cnt_o}, nframes);
  endtask

  task automatic begin_run(input int mode, input int frames,
                           input logic [15:0] solid);
    @(posedge clk); #1;
    mode_i = 2'(mode);
    frames_i = 16'(frames);
    solid_i = solid;
    done_cnt = 0;
    last_done = -1;
    push_frame(mode, solid);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("busy_on_start", {31'd0, busy_o}, 1);
  endtask

  task automatic end_run(input int nframes);
    @(negedge clk);
    check("busy_after_last", {31'd0, busy_o}, 0);
    check("idle_vsync", {31'd0, cam_vsync_o}, 1);
    repeat (4 * HTS * CLK_DIV) @(negedge clk);
    check("done_pulses", done_cnt, nframes);
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", {31'd0, busy_o}, 0);
    check("cnt_hold", {16'd0, frame_cnt_o}, nframes);
  endtask

  task automatic check_reset_vals();
    check("rst_pclk", {31'd0, cam_pclk_o}, 0);
    check("rst_vsync", {31'd0, cam_vsync_o}, 1);
    check("rst_href", {31'd0, cam_href_o}, 0);
    check("rst_data", {24'd0, cam_half_pixel_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, frame_done_o}, 0);
    check("rst_cnt", {16'd0, frame_cnt_o}, 0);
    check("rst_crc", {16'd0, crc_o}, 0);
  endtask

  function automatic logic [15:0] exp_crc();
`ifdef DVP_PATTERN_CRC_EN
    return model_crc;
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    int m;
    logic [15:0] s;
    repeat (3) @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset_i = 1'b0;

    // bars, single frame
    begin_run(0, 1, 16'(0 + $urandom));
    wait_done(1);
    end_run(1);

    // stop while idle must not leak into the next run
    @(posedge clk); #1;
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;

    // ramp, 3 frames; mode/solid changed mid-frame, start ignored
    begin_run(1, 3, 16'(0 + $urandom));
    for (int f = 0; f < 3; f++) begin
      wait_href();
      m = int'($urandom_range(0, 3));
      s = 16'(0 + $urandom);
      @(posedge clk); #1;
      mode_i = 2'(m);
      solid_i = s;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (f < 2) push_frame(m, s);
      wait_done(f + 1);
    end
    end_run(3);

    // continuous solid colour, stop during frame 2
    s = 16'(0 + $urandom);
    begin_run(3, 0, s);
    wait_href();
    push_frame(3, s);
    wait_done(1);
    check("crc_frame1", {16'd0, crc_o}, {16'd0, exp_crc()});
    wait_href();
    repeat ($urandom_range(1, 400)) @(posedge clk);
    #1;
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
    wait_done(2);
    check("crc_frame2", {16'd0, crc_o}, {16'd0, exp_crc()});
    end_run(2);

    // reset in the middle of an active line
    begin_run(2, 0, 16'(0 + $urandom));
    wait_href();
    repeat ($urandom_range(1, 60)) @(negedge clk);
    @(posedge clk); #1;
    reset_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    reset_i = 1'b0;

    // full checker frame after the reset
    begin_run(2, 1, 16'(0 + $urandom));
    wait_done(1);
    end_run(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #(20 * FRAME_CYC * 10);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dvp_pattern_source.md
# dvp_pattern_source

Synthesizable, parametrised DVP camera source that emits OV5640-style VSYNC/HREF/PCLK framing with RGB565 test patterns, one byte per PCLK.
- It replaces hand-written bench stimulus: it drives the `cam_*` inputs of the DVP receive path in simulation.
- It also drives the same path on hardware, so the capture/HDMI chain can be brought up without a sensor.
- Geometry, blanking and PCLK rate are parameters; pattern mode, frame count and solid colour are run-time inputs.

## Interface
- `H_ACTIVE`, 640, active pixels per line (each pixel = 2 bytes)
- `V_ACTIVE`, 480, active lines per frame
- `HTS`, 1896, byte periods per line; must be ≥ `H_FRONT` + 2·`H_ACTIVE` + 1
- `H_FRONT`, 20, byte periods of HREF low before active bytes
- `VSYNC_LINES`, 3, lines of VSYNC high at frame start
- `V_BACK`, 10, blank lines after VSYNC falls
- `V_FRONT`, 10, lines of VSYNC high after last active line
- `CLK_DIV`, 2, `clk_i` cycles per byte period; even, ≥ 2
- `clk_i` in 1: sole clock
- `reset_i` in 1: synchronous, active-high reset
- `start_i` in 1: start request, sampled only in IDLE
- `stop_i` in 1: finish current frame, then IDLE
- `frames_i` in 16: frames per run; 0 = continuous
- `mode_i` in 2: 0 bars, 1 ramp, 2 checker, 3 solid
- `solid_i` in 16: RGB565 colour for mode 3
- `cam_pclk_o` out 1: generated pixel clock
- `cam_vsync_o` out 1: frame sync, high = blanking
- `cam_href_o` out 1: line valid
- `cam_half_pixel_o` out 8: byte, high byte first
- `busy_o` out 1: run in progress
- `frame_done_o` out 1: one-`clk_i` pulse at each frame end
- `frame_cnt_o` out 16: frames completed in current run
- `crc_o` out 16: CRC of last frame's active bytes (see Configuration)

## Operation
- Phase counter `0..CLK_DIV-1` runs freely after reset.
  - `cam_pclk_o` = 0 for phases `0..CLK_DIV/2-1`, 1 otherwise.
  - A byte period starts at phase 0. `vsync`, `href` and `data` update only there, so the receiver samples stable data on PCLK rising.
- FSM states: IDLE → VS → VBP → ACT → VFP → (VS | IDLE).
  - IDLE: vsync=1, href=0, data=0.
  - VS: vsync=1 for `VSYNC_LINES`·`HTS` periods.
  - VBP: vsync=0 for `V_BACK`·`HTS` periods.
  - ACT: `V_ACTIVE` lines. Each line is `H_FRONT` periods href=0, then 2·`H_ACTIVE` periods href=1 with data, then the remaining `HTS`−`H_FRONT`−2·`H_ACTIVE` periods href=0. vsync=0 throughout.
  - VFP: vsync=1 for `V_FRONT`·`HTS` periods.
- At the last VFP period: `frame_done_o` pulses and `frame_cnt_o` increments.
  - If `frame_cnt_o`+1 == `frames_i` (`frames_i`≠0), or `stop_i` has been seen since the run started, go to IDLE.
  - Otherwise go to VS.
- `mode_i` and `solid_i` are latched at every VS entry. Changes mid-frame have no effect until the next frame.
- Pixel (x,y), 0-based:
  - bars: index = ⌊8x/`H_ACTIVE`⌋ selects FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Use an incremental accumulator, no divider.
  - ramp: (x+y) mod 2^16.
  - checker: FFFF if x[5]^y[5], else 0000.
  - solid: latched `solid_i`.
- `start_i` while busy is ignored. `stop_i` while IDLE is ignored. `stop_i` is sticky until IDLE.
- `frame_cnt_o` clears on a run start.

## Timing
- Reset values:
  - `cam_pclk_o`=0, `cam_vsync_o`=1, `cam_href_o`=0, `cam_half_pixel_o`=0
  - `busy_o`=0, `frame_done_o`=0, `frame_cnt_o`=0, `crc_o`=0
  - phase=0, FSM=IDLE
- Reset mid-frame: all outputs take their reset values on the next `clk_i` edge, and any partial frame is discarded.
- `start_i` accepted at edge t: `busy_o`=1 from t+1. VS begins at the next phase-0 boundary, within `CLK_DIV` cycles.
- `busy_o` falls on the same edge that FSM enters IDLE, which is one cycle after the last `frame_done_o` pulse.
- Frame length = (`VSYNC_LINES`+`V_BACK`+`V_ACTIVE`+`V_FRONT`)·`HTS`·`CLK_DIV` `clk_i` cycles, exact.
- All counters saturate-free and wrap only as specified. `frame_cnt_o` wraps at 2^16 in continuous mode.

## Configuration
- `DVP_PATTERN_CRC_EN` defined:
  - CRC-16/CCITT (poly 0x1021, init FFFF, MSB first) runs over every href=1 byte of a frame.
  - Result is latched into `crc_o` on `frame_done_o`; the running CRC reinits at VS entry.
- `DVP_PATTERN_CRC_EN` undefined: no CRC logic; `crc_o` is tied to 0.

## Test plan
- Small geometry (`H_ACTIVE`=8, `V_ACTIVE`=4, `HTS`=24, `H_FRONT`=2, `VSYNC_LINES`=`V_BACK`=`V_FRONT`=1, `CLK_DIV`=2), bars, `frames_i`=1 → line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00 on every line.
  - Frame = 7·24·2 = 336 cycles; exactly one `frame_done_o`; `busy_o` then 0.
- `H_ACTIVE`=64, checker → pixel x=31 is 0000, x=32 is FFFF on line 0; on line 32, x=0 is FFFF.
- Ramp, `frames_i`=3 → pixel (5,2)=0007.
  - 3 `frame_done_o` pulses exactly one frame length apart; `frame_cnt_o`=3; VSYNC stays high across VFP→VS.
- `start_i` during a run is ignored.
  - `frames_i`=0 with `stop_i` mid-frame 2 → frame 2 completes fully, then IDLE; `frame_cnt_o`=2.
- `reset_i` asserted mid-ACT line → next cycle vsync=1, href=0, data=0, `busy_o`=0.
  - A new `start_i` then produces a full, correct frame.
- `DVP_PATTERN_CRC_EN`, solid 1234, 2 frames → `crc_o` equals the bench model CRC and is identical for both frames.
  - Macro undefined → `crc_o` stays 0.
